// File: rtl/sim_irq_watchdog_if.sv
// Watchdog bus: core status in, interrupt requests and run status out.
// master is the core/harness side, slave is the watchdog.
interface sim_irq_watchdog_if #(
  parameter int NUM_IRQ   = 1,
  parameter int OPCODE_W  = 32,
  parameter int TIMEOUT_W = 10
);
  logic                 ps_idle;
  logic [OPCODE_W-1:0]  pm_op;
  logic                 pcstk_ovf;
  logic [NUM_IRQ-1:0]   irq_en;
  logic [NUM_IRQ-1:0]   irq_ack;
  logic [NUM_IRQ-1:0]   irq;
  logic                 done;
  logic [1:0]           stop_code;
  logic                 halt_req;
  logic [TIMEOUT_W-1:0] cycle_cnt;

  modport master (
    output ps_idle, pm_op, pcstk_ovf,
    output irq_en, irq_ack,
    input  irq, done, stop_code,
    input  halt_req, cycle_cnt
  );

  modport slave (
    input  ps_idle, pm_op, pcstk_ovf,
    input  irq_en, irq_ack,
    output irq, done, stop_code,
    output halt_req, cycle_cnt
  );
endinterface

// File: rtl/sim_irq_watchdog.sv
// Run monitor and pseudo-random interrupt source for core_top.
// Ends the run on FINISH, stack overflow or timeout, then halts.
module sim_irq_watchdog #(
  parameter int NUM_IRQ      = 1,
  parameter int CNT_W        = 3,
  parameter int TIMEOUT_W    = 10,
  parameter int DRAIN_CYCLES = 5,
  parameter int OPCODE_W     = 32,
  parameter logic [OPCODE_W-1:0] FINISH_MASK = 32'hFFC0_0000,
  parameter logic [OPCODE_W-1:0] FINISH_VAL  = 32'h0040_0000,
  parameter int IRQ_LEVEL    = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic clk,
  input logic reset,
  sim_irq_watchdog_if.slave bus
);

  localparam int DW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  if (NUM_IRQ < 1 || NUM_IRQ > 8 ||
      NUM_IRQ * CNT_W > 16) begin : g_bad_irq
    $error("sim_irq_watchdog: bad NUM_IRQ/CNT_W");
  end
  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("sim_irq_watchdog: DRAIN_CYCLES < 1");
  end
  if (LFSR_SEED == 16'h0) begin : g_bad_seed
    $error("sim_irq_watchdog: zero LFSR_SEED");
  end

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_nxt;
  logic [TIMEOUT_W-1:0] cycle_q;
  logic [DW-1:0]        drain_q;
  logic [1:0]           stop_q, code;
  logic                 done_q, halt_q;
  logic [NUM_IRQ-1:0]   irq_q, irq_d;
  logic [CNT_W-1:0]     cnt_q [NUM_IRQ];
  logic [CNT_W-1:0]     cnt_d [NUM_IRQ];
  logic                 fin, tmo, term;

  assign fin  = (bus.pm_op & FINISH_MASK) == FINISH_VAL;
  assign tmo  = &cycle_q;
  assign term = (state_q == S_RUN) &&
                (fin || bus.pcstk_ovf || tmo);

  always_comb begin
    code = 2'b11;
    if (fin)                code = 2'b01;
    else if (bus.pcstk_ovf) code = 2'b10;
  end

  assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^
                    (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (term) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == '0) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  // A pending level irq parks its counter at 0 until acknowledged.
  always_comb begin
    cnt_d = cnt_q;
    irq_d = irq_q;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (state_q != S_RUN || term) begin
        irq_d[k] = 1'b0;
      end else if (!bus.irq_en[k]) begin
        irq_d[k] = 1'b0;
      end else if (IRQ_LEVEL != 0 && irq_q[k]) begin
        if (bus.irq_ack[k]) irq_d[k] = 1'b0;
        if (cnt_q[k] != '0 && bus.ps_idle)
          cnt_d[k] = cnt_q[k] - 1'b1;
      end else if (cnt_q[k] == '0) begin
        cnt_d[k] = lfsr_q[k*CNT_W +: CNT_W];
        irq_d[k] = bus.ps_idle;
      end else begin
        irq_d[k] = 1'b0;
        if (bus.ps_idle) cnt_d[k] = cnt_q[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q  <= LFSR_SEED;
      cycle_q <= '0;
      drain_q <= '0;
      stop_q  <= 2'b00;
      done_q  <= 1'b0;
      halt_q  <= 1'b0;
      irq_q   <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      lfsr_q <= lfsr_nxt;
      irq_q  <= irq_d;
      cnt_q  <= cnt_d;
      if (state_q == S_RUN) begin
        if (term) begin
          stop_q  <= code;
          done_q  <= 1'b1;
          drain_q <= DW'(DRAIN_CYCLES - 1);
        end else begin
          cycle_q <= cycle_q + 1'b1;
        end
      end else if (state_q == S_DRAIN) begin
        if (drain_q == '0) halt_q  <= 1'b1;
        else               drain_q <= drain_q - 1'b1;
      end
    end
  end

  assign bus.irq       = irq_q;
  assign bus.done      = done_q;
  assign bus.stop_code = stop_q;
  assign bus.halt_req  = halt_q;
  assign bus.cycle_cnt = cycle_q;

endmodule

// File: tb/tb_sim_irq_watchdog.sv
// Bench for sim_irq_watchdog: three configurations driven with
// directed vectors and short multi-cycle sequences.
module tb_sim_irq_watchdog;

  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sim_irq_watchdog_if #(.NUM_IRQ(1), .TIMEOUT_W(10)) b0();
  sim_irq_watchdog_if #(.NUM_IRQ(1), .TIMEOUT_W(4))  b1();
  sim_irq_watchdog_if #(.NUM_IRQ(2), .TIMEOUT_W(10)) b2();

  sim_irq_watchdog #(.NUM_IRQ(1), .TIMEOUT_W(10)) u0 (
    .clk(clk), .reset(rst0), .bus(b0)
  );
  sim_irq_watchdog #(.NUM_IRQ(1), .TIMEOUT_W(4)) u1 (
    .clk(clk), .reset(rst1), .bus(b1)
  );
  sim_irq_watchdog #(
    .NUM_IRQ(2), .TIMEOUT_W(10), .IRQ_LEVEL(1)
  ) u2 (
    .clk(clk), .reset(rst2), .bus(b2)
  );

  localparam logic [31:0] FIN = 32'h0040_0000;

  typedef struct {
    logic        rst;
    logic [31:0] op;
    logic        ovf;
    logic        done;
    logic [1:0]  code;
    logic        halt;
    logic [9:0]  cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [31:0] st0();
    return {17'd0, b0.irq, b0.done, b0.stop_code,
            b0.halt_req, b0.cycle_cnt};
  endfunction

  initial begin
    logic [15:0] lf;
    int nf, hi, n;
    logic seen, bad1;

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    b0.ps_idle = 1'b0; b0.pm_op = '0; b0.pcstk_ovf = 1'b0;
    b0.irq_en = '0; b0.irq_ack = '0;
    b1.ps_idle = 1'b0; b1.pm_op = '0; b1.pcstk_ovf = 1'b0;
    b1.irq_en = '0; b1.irq_ack = '0;
    b2.ps_idle = 1'b0; b2.pm_op = '0; b2.pcstk_ovf = 1'b0;
    b2.irq_en = '0; b2.irq_ack = '0;

    // rst, op, ovf | done, code, halt, cycle_cnt
    tbl[0]  = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 10'd0};
    tbl[1]  = '{1'b1, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 10'd1};
    tbl[2]  = '{1'b1, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 10'd2};
    tbl[3]  = '{1'b1, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0, 10'd2};
    tbl[4]  = '{1'b1, FIN,   1'b0, 1'b1, 2'b10, 1'b0, 10'd2};
    tbl[5]  = '{1'b1, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0, 10'd2};
    tbl[6]  = '{1'b1, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 10'd2};
    tbl[7]  = '{1'b1, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 10'd2};
    tbl[8]  = '{1'b1, 32'h0, 1'b0, 1'b1, 2'b10, 1'b1, 10'd2};
    tbl[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 10'd0};
    tbl[10] = '{1'b1, FIN,   1'b1, 1'b1, 2'b01, 1'b0, 10'd0};
    tbl[11] = '{1'b1, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0, 10'd0};
    tbl[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 10'd0};
    tbl[13] = '{1'b1, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 10'd1};

    tick();
    for (int i = 0; i < 14; i++) begin
      rst0 = tbl[i].rst;
      b0.pm_op = tbl[i].op;
      b0.pcstk_ovf = tbl[i].ovf;
      tick();
      chk($sformatf("vec%0d", i), st0(),
          {17'd0, 1'b0, tbl[i].done, tbl[i].code,
           tbl[i].halt, tbl[i].cnt});
    end

    // finish opcode presented when cycle_cnt is 20
    rst0 = 1'b0; tick(); rst0 = 1'b1;
    n = 0;
    while (b0.cycle_cnt != 10'd20 && n < 50) begin
      tick(); n++;
    end
    chk("reach20", 32'(b0.cycle_cnt), 32'd20);
    b0.pm_op = FIN;
    tick();
    b0.pm_op = '0;
    chk("fin_code", {b0.done, b0.stop_code}, 3'b101);
    chk("fin_cnt", 32'(b0.cycle_cnt), 32'd20);
    for (int i = 0; i < 4; i++) tick();
    chk("fin_halt4", 32'(b0.halt_req), 32'd0);
    tick();
    chk("fin_halt5", 32'(b0.halt_req), 32'd1);
    chk("fin_frozen", 32'(b0.cycle_cnt), 32'd20);

    // timeout with a 4-bit cycle counter
    rst1 = 1'b0; tick(); rst1 = 1'b1;
    n = 0;
    while (!b1.done && n < 40) begin
      tick(); n++;
    end
    chk("tmo_edges", n, 32'd16);
    chk("tmo_code", 32'(b1.stop_code), 32'd3);
    chk("tmo_cnt", 32'(b1.cycle_cnt), 32'd15);
    for (int i = 0; i < 4; i++) tick();
    chk("tmo_halt4", 32'(b1.halt_req), 32'd0);
    tick();
    chk("tmo_halt5", 32'(b1.halt_req), 32'd1);

    // core never idle: no interrupts
    rst0 = 1'b0; b0.irq_en = 1'b1; b0.ps_idle = 1'b0;
    tick(); rst0 = 1'b1;
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (b0.irq) hi++;
    end
    chk("busy_quiet", hi, 32'd0);

    // always idle: pulse spacing follows the LFSR
    rst0 = 1'b0; b0.ps_idle = 1'b1;
    tick(); rst0 = 1'b1;
    lf = 16'hACE1;
    nf = 0;
    hi = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (b0.irq) hi++;
      chk($sformatf("spacing_c%0d", c),
          32'(b0.irq), 32'(c == nf));
      if (c == nf) nf = c + int'(lf[2:0]) + 1;
      lf = lstep(lf);
    end
    chk("pulses_seen", 32'(hi > 8), 32'd1);

    // level mode, two channels, channel 1 disabled
    rst2 = 1'b0; b2.ps_idle = 1'b1; b2.irq_en = 2'b01;
    tick(); rst2 = 1'b1;
    tick();
    chk("lvl_first", 32'(b2.irq), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("lvl_hold%0d", i), 32'(b2.irq), 32'd1);
    end
    b2.irq_ack = 2'b01;
    tick();
    b2.irq_ack = 2'b00;
    chk("lvl_ack", 32'(b2.irq), 32'd0);
    seen = 1'b0; bad1 = 1'b0; n = 0;
    while (!seen && n < 16) begin
      tick(); n++;
      seen = b2.irq[0];
      if (b2.irq[1]) bad1 = 1'b1;
    end
    chk("lvl_refire", 32'(seen), 32'd1);
    chk("lvl_ch1_off", 32'(bad1), 32'd0);
    b2.irq_en = 2'b00;
    tick();
    chk("lvl_en_clr", 32'(b2.irq), 32'd0);
    b2.irq_en = 2'b01;
    seen = 1'b0; n = 0;
    while (!seen && n < 16) begin
      tick(); n++;
      seen = b2.irq[0];
    end
    chk("lvl_refire2", 32'(seen), 32'd1);
    b2.irq_ack = 2'b01;
    b2.pm_op = FIN;
    tick();
    b2.irq_ack = 2'b00;
    b2.pm_op = '0;
    chk("ack_term",
        {b2.irq, b2.done, b2.stop_code}, 5'b00101);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
